// File: rtl/sync_fifo_asym_pkg.sv
// Shared helpers for the asymmetric-width FIFO: width ratios, slot counts, pointer widths, lane order.
// Latency: none (elaboration-time functions and types only).
// Backpressure: n/a.
package sync_fifo_pkg;

  localparam int MIN_DATA_WIDTH = 8;
  localparam int MIN_FIFO_DEPTH = 2;

  typedef enum logic {
    OUT_COMB = 1'b0,
    OUT_REG  = 1'b1
  } out_mode_e;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int narrow_w(input int wi, input int wo);
    return (wi < wo) ? wi : wo;
  endfunction

  function automatic int wide_w(input int wi, input int wo);
    return (wi > wo) ? wi : wo;
  endfunction

  function automatic int ratio(input int wi, input int wo);
    return wide_w(wi, wo) / narrow_w(wi, wo);
  endfunction

  // Storage is counted in narrow slots; capacity is FIFO_DEPTH wide words.
  function automatic int slot_count(input int wi, input int wo, input int depth);
    return depth * ratio(wi, wo);
  endfunction

  function automatic int ptr_aw(input int wi, input int wo, input int depth);
    return $clog2(slot_count(wi, wo, depth));
  endfunction

  // One extra bit over the slot address separates full from empty.
  function automatic int level_w(input int wi, input int wo, input int depth);
    return ptr_aw(wi, wo, depth) + 1;
  endfunction

  // Position of the idx-th narrow word (in arrival order) inside an n-lane wide word.
  function automatic int lane_pos(input int idx, input int n, input bit msb_first);
    return msb_first ? (n - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/sync_fifo_asym_if.sv
// Write/read handshake bundle of the asymmetric FIFO.
// Latency: none (wires only).
// Backpressure: fifo_full / fifo_empty flags; strobes while blocked are dropped and flagged.
interface sync_fifo_asym_if #(
  parameter int DATA_WIDTH_I = 64,
  parameter int DATA_WIDTH_O = 256,
  parameter int FIFO_DEPTH   = 8
);
  localparam int LVL_W = sync_fifo_pkg::level_w(DATA_WIDTH_I, DATA_WIDTH_O, FIFO_DEPTH);

  logic                    fifo_flush;
  logic                    fifo_wr;
  logic [DATA_WIDTH_I-1:0] fifo_din;
  logic                    fifo_full;
  logic                    fifo_almost_full;
  logic                    fifo_rd;
  logic [DATA_WIDTH_O-1:0] fifo_dout;
  logic                    fifo_empty;
  logic                    fifo_almost_empty;
  logic [LVL_W-1:0]        fifo_level;
  logic                    fifo_wr_err;
  logic                    fifo_rd_err;

  modport master (
    output fifo_flush, fifo_wr, fifo_din, fifo_rd,
    input  fifo_full, fifo_almost_full, fifo_dout, fifo_empty,
    input  fifo_almost_empty, fifo_level, fifo_wr_err, fifo_rd_err
  );

  modport slave (
    input  fifo_flush, fifo_wr, fifo_din, fifo_rd,
    output fifo_full, fifo_almost_full, fifo_dout, fifo_empty,
    output fifo_almost_empty, fifo_level, fifo_wr_err, fifo_rd_err
  );

endinterface

// File: rtl/sync_fifo_asym_mem.sv
// Narrow-slot register array with multi-slot write and read ports (aligned, address wraps).
// Latency: write lands at the clock edge; read port is combinational from rd_addr.
// Backpressure: none; the caller qualifies wr_en.
module sync_fifo_asym_mem
  import sync_fifo_pkg::*;
#(
  parameter int NARROW_W       = 64,
  parameter int SLOTS          = 32,
  parameter int WR_N           = 1,
  parameter int RD_N           = 4,
  parameter bit PACK_MSB_FIRST = 1'b0,
  localparam int AW            = $clog2(SLOTS)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [WR_N*NARROW_W-1:0] wr_dat,
  input  logic [AW-1:0]            rd_addr,
  output logic [RD_N*NARROW_W-1:0] rd_dat
);

  logic [NARROW_W-1:0] mem [SLOTS];

  // Scatter the write lanes into consecutive slots in arrival order.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WR_N; i++) begin
        mem[wr_addr + AW'(i)] <= wr_dat[lane_pos(i, WR_N, PACK_MSB_FIRST)*NARROW_W +: NARROW_W];
      end
    end
  end

  // Gather consecutive slots into read lanes using the same lane order as the write side.
  for (genvar g = 0; g < RD_N; g++) begin : g_rd
    assign rd_dat[lane_pos(g, RD_N, PACK_MSB_FIRST)*NARROW_W +: NARROW_W] = mem[rd_addr + AW'(g)];
  end

endmodule

// File: rtl/sync_fifo_asym.sv
// Synchronous FIFO with independent write/read widths, flags, fill level and error pulses.
// Latency: flags/level follow an accepting edge by one cycle; dout show-ahead (mode 0) or loaded on read (mode 1).
// Backpressure: writes while full and reads while empty are dropped and pulse the matching err flag.
module sync_fifo_asym
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH_I   = 64,
  parameter int DATA_WIDTH_O   = 256,
  parameter int FIFO_DEPTH     = 8,
  parameter int OUTPUT_MODE    = 0,
  parameter bit PACK_MSB_FIRST = 1'b0,
  parameter int AF_LEVEL       = FIFO_DEPTH * ratio(DATA_WIDTH_I, DATA_WIDTH_O) - 1,
  parameter int AE_LEVEL       = ratio(DATA_WIDTH_I, DATA_WIDTH_O)
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_asym_if.slave bus
);

  localparam int NW    = narrow_w(DATA_WIDTH_I, DATA_WIDTH_O);
  localparam int SLOTS = slot_count(DATA_WIDTH_I, DATA_WIDTH_O, FIFO_DEPTH);
  localparam int AW    = ptr_aw(DATA_WIDTH_I, DATA_WIDTH_O, FIFO_DEPTH);
  localparam int PW    = level_w(DATA_WIDTH_I, DATA_WIDTH_O, FIFO_DEPTH);
  localparam int WR_N  = DATA_WIDTH_I / NW;
  localparam int RD_N  = DATA_WIDTH_O / NW;

  localparam logic [PW-1:0] WR_STEP = PW'(WR_N);
  localparam logic [PW-1:0] RD_STEP = PW'(RD_N);
  localparam logic [PW-1:0] CAP     = PW'(SLOTS);
  localparam logic [PW-1:0] AF_L    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L    = PW'(AE_LEVEL);

  if (!is_pow2(DATA_WIDTH_I) || DATA_WIDTH_I < MIN_DATA_WIDTH) begin : g_bad_wi
    $error("DATA_WIDTH_I must be a power of two and at least 8");
  end
  if (!is_pow2(DATA_WIDTH_O) || DATA_WIDTH_O < MIN_DATA_WIDTH) begin : g_bad_wo
    $error("DATA_WIDTH_O must be a power of two and at least 8");
  end
  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < MIN_FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (AF_LEVEL > SLOTS || AF_LEVEL < 0 || AE_LEVEL > SLOTS || AE_LEVEL < 0) begin : g_bad_lvl
    $error("AF_LEVEL/AE_LEVEL must lie within the FIFO capacity");
  end

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           level;
  logic [PW-1:0]           free_slots;
  logic                    full;
  logic                    empty;
  logic                    wr_ok;
  logic                    rd_ok;
  logic                    wr_err_q;
  logic                    rd_err_q;
  logic [DATA_WIDTH_O-1:0] mem_rd_dat;

  // Occupancy comes straight from the registered pointers; the extra MSB keeps full != empty.
  assign level      = wr_ptr - rd_ptr;
  assign free_slots = CAP - level;
  assign full       = free_slots < WR_STEP;
  assign empty      = level < RD_STEP;

  // Flush wins over both strobes, so neither side is accepted or flagged that cycle.
  assign wr_ok = bus.fifo_wr && !full && !bus.fifo_flush;
  assign rd_ok = bus.fifo_rd && !empty && !bus.fifo_flush;

  // Pointer update: flush clears, otherwise each side advances by its own slot count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + WR_STEP;
      if (rd_ok) rd_ptr <= rd_ptr + RD_STEP;
    end
  end

  // One-cycle error pulses for strobes that hit a blocked side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.fifo_wr && full && !bus.fifo_flush;
      rd_err_q <= bus.fifo_rd && empty && !bus.fifo_flush;
    end
  end

  sync_fifo_asym_mem #(
    .NARROW_W       (NW),
    .SLOTS          (SLOTS),
    .WR_N           (WR_N),
    .RD_N           (RD_N),
    .PACK_MSB_FIRST (PACK_MSB_FIRST)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_dat  (bus.fifo_din),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_dat  (mem_rd_dat)
  );

  if (OUTPUT_MODE == int'(OUT_REG)) begin : g_reg_out
    logic [DATA_WIDTH_O-1:0] dout_q;

    // Output register loads the head word on each accepted read and holds it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (bus.fifo_flush) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= mem_rd_dat;
      end
    end

    assign bus.fifo_dout = dout_q;
  end else begin : g_comb_out
    assign bus.fifo_dout = empty ? '0 : mem_rd_dat;
  end

  assign bus.fifo_full         = full;
  assign bus.fifo_empty        = empty;
  assign bus.fifo_almost_full  = level >= AF_L;
  assign bus.fifo_almost_empty = level <= AE_L;
  assign bus.fifo_level        = level;
  assign bus.fifo_wr_err       = wr_err_q;
  assign bus.fifo_rd_err       = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_asym.sv
// Bench for sync_fifo_asym: 64->256 show-ahead, 256->64 registered, 64->64 plain.
// Latency: n/a.
// Backpressure: n/a.
module tb_sync_fifo_asym;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_asym_if #(.DATA_WIDTH_I(64),  .DATA_WIDTH_O(256), .FIFO_DEPTH(8)) up_if ();
  sync_fifo_asym_if #(.DATA_WIDTH_I(256), .DATA_WIDTH_O(64),  .FIFO_DEPTH(8)) dn_if ();
  sync_fifo_asym_if #(.DATA_WIDTH_I(64),  .DATA_WIDTH_O(64),  .FIFO_DEPTH(8)) eq_if ();

  sync_fifo_asym #(.DATA_WIDTH_I(64), .DATA_WIDTH_O(256), .FIFO_DEPTH(8), .OUTPUT_MODE(0))
    u_up (.clk(clk), .rst_n(rst_n), .bus(up_if));
  sync_fifo_asym #(.DATA_WIDTH_I(256), .DATA_WIDTH_O(64), .FIFO_DEPTH(8), .OUTPUT_MODE(1))
    u_dn (.clk(clk), .rst_n(rst_n), .bus(dn_if));
  sync_fifo_asym #(.DATA_WIDTH_I(64), .DATA_WIDTH_O(64), .FIFO_DEPTH(8), .OUTPUT_MODE(0))
    u_eq (.clk(clk), .rst_n(rst_n), .bus(eq_if));

  int n_vec = 0;
  int n_err = 0;

  // Sampled outputs of the selected instance.
  logic         o_full, o_af, o_empty, o_ae, o_werr, o_rerr;
  int           o_level;
  logic [255:0] o_dout;

  // Reference model: queue of 64-bit narrow units plus the instance's geometry.
  logic [63:0]  mq[$];
  logic [255:0] m_dreg;
  int           m_wn, m_rn, m_cap, m_af, m_ae;
  bit           m_mode;
  bit           e_wr_err, e_rd_err;

  typedef struct {
    bit           fl, wr, rd;
    logic [63:0]  din;
    int           lvl;
    bit           emp, full, werr, rerr;
    logic [255:0] dout;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int w, input bit fl, input bit wr, input logic [255:0] din, input bit rd);
    up_if.fifo_flush = 0; up_if.fifo_wr = 0; up_if.fifo_rd = 0; up_if.fifo_din = '0;
    dn_if.fifo_flush = 0; dn_if.fifo_wr = 0; dn_if.fifo_rd = 0; dn_if.fifo_din = '0;
    eq_if.fifo_flush = 0; eq_if.fifo_wr = 0; eq_if.fifo_rd = 0; eq_if.fifo_din = '0;
    case (w)
      0: begin up_if.fifo_flush = fl; up_if.fifo_wr = wr; up_if.fifo_din = din[63:0]; up_if.fifo_rd = rd; end
      1: begin dn_if.fifo_flush = fl; dn_if.fifo_wr = wr; dn_if.fifo_din = din;       dn_if.fifo_rd = rd; end
      default: begin eq_if.fifo_flush = fl; eq_if.fifo_wr = wr; eq_if.fifo_din = din[63:0]; eq_if.fifo_rd = rd; end
    endcase
  endtask

  task automatic sample(input int w);
    case (w)
      0: begin
        o_full = up_if.fifo_full; o_af = up_if.fifo_almost_full; o_empty = up_if.fifo_empty;
        o_ae = up_if.fifo_almost_empty; o_level = int'(up_if.fifo_level);
        o_werr = up_if.fifo_wr_err; o_rerr = up_if.fifo_rd_err; o_dout = 256'(up_if.fifo_dout);
      end
      1: begin
        o_full = dn_if.fifo_full; o_af = dn_if.fifo_almost_full; o_empty = dn_if.fifo_empty;
        o_ae = dn_if.fifo_almost_empty; o_level = int'(dn_if.fifo_level);
        o_werr = dn_if.fifo_wr_err; o_rerr = dn_if.fifo_rd_err; o_dout = 256'(dn_if.fifo_dout);
      end
      default: begin
        o_full = eq_if.fifo_full; o_af = eq_if.fifo_almost_full; o_empty = eq_if.fifo_empty;
        o_ae = eq_if.fifo_almost_empty; o_level = int'(eq_if.fifo_level);
        o_werr = eq_if.fifo_wr_err; o_rerr = eq_if.fifo_rd_err; o_dout = 256'(eq_if.fifo_dout);
      end
    endcase
  endtask

  task automatic model_select(input int w);
    case (w)
      0:       begin m_wn = 1; m_rn = 4; m_cap = 32; m_mode = 0; m_af = 31; m_ae = 4; end
      1:       begin m_wn = 4; m_rn = 1; m_cap = 32; m_mode = 1; m_af = 31; m_ae = 4; end
      default: begin m_wn = 1; m_rn = 1; m_cap = 8;  m_mode = 0; m_af = 7;  m_ae = 1; end
    endcase
    mq.delete();
    m_dreg = '0;
  endtask

  // Oldest n narrow units, first arrival in the least significant lane.
  function automatic logic [255:0] head(input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*64 +: 64] = mq[i];
    return r;
  endfunction

  task automatic check_all(input string tag);
    int sz;
    bit em;
    sz = mq.size();
    em = sz < m_rn;
    chk({tag, ".level"}, 256'(o_level), 256'(sz));
    chk({tag, ".full"},  256'(o_full),  256'((m_cap - sz) < m_wn));
    chk({tag, ".empty"}, 256'(o_empty), 256'(em));
    chk({tag, ".af"},    256'(o_af),    256'(sz >= m_af));
    chk({tag, ".ae"},    256'(o_ae),    256'(sz <= m_ae));
    chk({tag, ".wr_err"}, 256'(o_werr), 256'(e_wr_err));
    chk({tag, ".rd_err"}, 256'(o_rerr), 256'(e_rd_err));
    chk({tag, ".dout"},  o_dout, m_mode ? m_dreg : (em ? 256'h0 : head(m_rn)));
  endtask

  // One clock of stimulus on instance w, predicted by the queue model and fully checked.
  task automatic cyc(input int w, input bit fl, input bit wr, input logic [255:0] din, input bit rd,
                     input string tag);
    int sz;
    bit mfull, mempty;
    sz = mq.size();
    mfull = (m_cap - sz) < m_wn;
    mempty = sz < m_rn;
    e_wr_err = 0;
    e_rd_err = 0;
    if (fl) begin
      mq.delete();
      m_dreg = '0;
    end else begin
      e_wr_err = wr && mfull;
      e_rd_err = rd && mempty;
      if (rd && !mempty) begin
        if (m_mode) m_dreg = head(m_rn);
        for (int i = 0; i < m_rn; i++) void'(mq.pop_front());
      end
      if (wr && !mfull) begin
        for (int i = 0; i < m_wn; i++) mq.push_back(din[i*64 +: 64]);
      end
    end
    drive(w, fl, wr, din, rd);
    @(posedge clk);
    #1;
    sample(w);
    check_all(tag);
  endtask

  task automatic rand_run(input int w, input int n, input int pwr, input int prd, input string tag);
    for (int k = 0; k < n; k++) begin
      bit fl, wr, rd;
      logic [255:0] din;
      fl = ($urandom_range(63) == 0);
      wr = ($urandom_range(99) < pwr);
      rd = ($urandom_range(99) < prd);
      din = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cyc(w, fl, wr, din, rd, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    // {fl, wr, rd, din} -> {level, empty, full, wr_err, rd_err, dout} for the 64->256 instance
    tbl[0]  = '{0, 1, 0, 64'h0,  1, 1, 0, 0, 0, 256'h0};
    tbl[1]  = '{0, 1, 0, 64'h1,  2, 1, 0, 0, 0, 256'h0};
    tbl[2]  = '{0, 1, 0, 64'h2,  3, 1, 0, 0, 0, 256'h0};
    tbl[3]  = '{0, 1, 0, 64'h3,  4, 0, 0, 0, 0, {64'h3, 64'h2, 64'h1, 64'h0}};
    tbl[4]  = '{0, 0, 1, 64'h0,  0, 1, 0, 0, 0, 256'h0};
    tbl[5]  = '{0, 0, 1, 64'h0,  0, 1, 0, 0, 1, 256'h0};
    tbl[6]  = '{0, 0, 0, 64'h0,  0, 1, 0, 0, 0, 256'h0};
    tbl[7]  = '{0, 1, 0, 64'hA,  1, 1, 0, 0, 0, 256'h0};
    tbl[8]  = '{0, 1, 0, 64'hB,  2, 1, 0, 0, 0, 256'h0};
    tbl[9]  = '{0, 1, 0, 64'hC,  3, 1, 0, 0, 0, 256'h0};
    tbl[10] = '{1, 0, 0, 64'h0,  0, 1, 0, 0, 0, 256'h0};
    tbl[11] = '{0, 1, 0, 64'h10, 1, 1, 0, 0, 0, 256'h0};
    tbl[12] = '{0, 1, 0, 64'h11, 2, 1, 0, 0, 0, 256'h0};
    tbl[13] = '{0, 1, 0, 64'h12, 3, 1, 0, 0, 0, 256'h0};
    tbl[14] = '{0, 1, 0, 64'h13, 4, 0, 0, 0, 0, {64'h13, 64'h12, 64'h11, 64'h10}};
    tbl[15] = '{1, 1, 1, 64'h55, 0, 1, 0, 0, 0, 256'h0};
    tbl[16] = '{1, 0, 1, 64'h0,  0, 1, 0, 0, 0, 256'h0};

    drive(0, 0, 0, '0, 0);
    #12;
    for (int w = 0; w < 3; w++) begin
      sample(w);
      chk($sformatf("reset%0d.full", w),   256'(o_full),  256'(0));
      chk($sformatf("reset%0d.empty", w),  256'(o_empty), 256'(1));
      chk($sformatf("reset%0d.af", w),     256'(o_af),    256'(0));
      chk($sformatf("reset%0d.ae", w),     256'(o_ae),    256'(1));
      chk($sformatf("reset%0d.level", w),  256'(o_level), 256'(0));
      chk($sformatf("reset%0d.errs", w),   256'({o_werr, o_rerr}), 256'(0));
      chk($sformatf("reset%0d.dout", w),   o_dout, 256'h0);
    end
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      drive(0, tbl[i].fl, tbl[i].wr, 256'(tbl[i].din), tbl[i].rd);
      @(posedge clk);
      #1;
      sample(0);
      chk($sformatf("tbl%0d.level", i),  256'(o_level), 256'(tbl[i].lvl));
      chk($sformatf("tbl%0d.empty", i),  256'(o_empty), 256'(tbl[i].emp));
      chk($sformatf("tbl%0d.full", i),   256'(o_full),  256'(tbl[i].full));
      chk($sformatf("tbl%0d.wr_err", i), 256'(o_werr),  256'(tbl[i].werr));
      chk($sformatf("tbl%0d.rd_err", i), 256'(o_rerr),  256'(tbl[i].rerr));
      chk($sformatf("tbl%0d.dout", i),   o_dout, tbl[i].dout);
    end

    // 64->256 fill to capacity, overflow, and simultaneous read/write while full.
    model_select(0);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 1, 256'(i + 100), 0, "fill");
      if (i == 29) chk("fill.af_at30", 256'(o_af), 256'(0));
      if (i == 30) chk("fill.af_at31", 256'(o_af), 256'(1));
    end
    chk("fill.full32", 256'({o_full, 6'(o_level)}), 256'({1'b1, 6'd32}));
    cyc(0, 0, 1, 256'h999, 0, "ovf");
    chk("ovf.wr_err", 256'({o_werr, 6'(o_level)}), 256'({1'b1, 6'd32}));
    cyc(0, 0, 0, '0, 0, "ovf_idle");
    chk("ovf.pulse_end", 256'(o_werr), 256'(0));
    cyc(0, 0, 1, 256'h777, 1, "rdwr_full");
    chk("rdwr_full.level", 256'(o_level), 256'(28));
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, '0, 1, "drain");
      if (i == 4) chk("drain.ae_at8", 256'(o_ae), 256'(0));
      if (i == 5) chk("drain.ae_at4", 256'(o_ae), 256'(1));
    end
    cyc(0, 0, 0, '0, 1, "rd_empty");
    chk("rd_empty.rd_err", 256'({o_rerr, o_dout}), 256'({1'b1, 256'h0}));
    rand_run(0, 400, 60, 20, "rand_up");

    // 256->64 registered output: one wide word read back as four narrow words.
    model_select(1);
    cyc(1, 0, 0, '0, 1, "dn_rd_empty");
    cyc(1, 0, 1, {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA}, 0, "dn_wr");
    chk("dn_wr.level", 256'(o_level), 256'(4));
    cyc(1, 0, 0, '0, 1, "dn_rd0"); chk("dn_rd0.A", o_dout, 256'hAAAA);
    cyc(1, 0, 0, '0, 1, "dn_rd1"); chk("dn_rd1.B", o_dout, 256'hBBBB);
    cyc(1, 0, 0, '0, 1, "dn_rd2"); chk("dn_rd2.C", o_dout, 256'hCCCC);
    cyc(1, 0, 0, '0, 1, "dn_rd3"); chk("dn_rd3.D", o_dout, 256'hDDDD);
    chk("dn_rd3.empty", 256'({o_empty, 6'(o_level)}), 256'({1'b1, 6'd0}));
    cyc(1, 0, 0, '0, 1, "dn_hold"); chk("dn_hold.dout", o_dout, 256'hDDDD);
    rand_run(1, 400, 25, 80, "rand_dn");

    // Asynchronous reset in the middle of a burst at level 17.
    model_select(0);
    cyc(0, 1, 0, '0, 0, "pre_rst_flush");
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 256'(i + 1), 0, "burst");
    chk("burst.level", 256'(o_level), 256'(17));
    #2 rst_n = 1'b0;
    #1;
    sample(0);
    chk("arst.level", 256'(o_level), 256'(0));
    chk("arst.flags", 256'({o_full, o_empty, o_af, o_ae, o_werr, o_rerr}), 256'(6'b010100));
    chk("arst.dout", o_dout, 256'h0);
    sample(1);
    chk("arst.dn_dout", o_dout, 256'h0);
    drive(0, 0, 0, '0, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // R = 1 plain FIFO after reset.
    model_select(2);
    cyc(2, 0, 1, 256'h1, 0, "eq_w1"); chk("eq_w1.dout", o_dout, 256'h1);
    cyc(2, 0, 1, 256'h2, 0, "eq_w2");
    cyc(2, 0, 0, '0, 1, "eq_r1");     chk("eq_r1.dout", o_dout, 256'h2);
    cyc(2, 0, 0, '0, 1, "eq_r2");     chk("eq_r2.empty", 256'(o_empty), 256'(1));
    rand_run(2, 200, 50, 50, "rand_eq");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_asym.md
# sync_fifo_asym

Parametrised synchronous FIFO with independent write and read widths (upsize, downsize or equal), selectable combinational or registered output, programmable almost-full/almost-empty flags, fill level, flush and error pulses. It is the next-generation replacement for the fixed 64-to-256 FIFO in the memory-control datapath and sits between the narrow host-side write stream and the wide memory-side read port, or the reverse.

## Interface
- DATA_WIDTH_I, 64, write data width; power of two, ≥8
- DATA_WIDTH_O, 256, read data width; power of two, ≥8
- FIFO_DEPTH, 8, capacity in words of max(DATA_WIDTH_I, DATA_WIDTH_O); power of two, ≥2
- OUTPUT_MODE, 0, 0 = combinational show-ahead output, 1 = registered output
- PACK_MSB_FIRST, 0, 0 = first narrow word occupies the LSBs of the wide word, 1 = MSBs
- AF_LEVEL, FIFO_DEPTH*R-1, almost_full threshold in narrow units (R = wide/narrow ratio)
- AE_LEVEL, R, almost_empty threshold in narrow units
- clk  in  1  clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- fifo_flush  in  1  synchronous clear of contents, pointers and output register
- fifo_wr  in  1  write strobe
- fifo_din  in  DATA_WIDTH_I  write data
- fifo_full  out  1  a write of DATA_WIDTH_I cannot be accepted
- fifo_almost_full  out  1  fifo_level ≥ AF_LEVEL
- fifo_rd  in  1  read strobe
- fifo_dout  out  DATA_WIDTH_O  read data
- fifo_empty  out  1  a read of DATA_WIDTH_O cannot be satisfied
- fifo_almost_empty  out  1  fifo_level ≤ AE_LEVEL
- fifo_level  out  $clog2(FIFO_DEPTH*R)+1  occupancy in narrow units
- fifo_wr_err  out  1  one-cycle pulse: fifo_wr while fifo_full
- fifo_rd_err  out  1  one-cycle pulse: fifo_rd while fifo_empty

## Operation
- Storage: FIFO_DEPTH*R slots of narrow width; pointers count narrow slots, wrap modulo FIFO_DEPTH*R, one extra MSB distinguishes full from empty.
- Write advances wr pointer by DATA_WIDTH_I/narrow slots; read advances rd pointer by DATA_WIDTH_O/narrow slots.
- fifo_full = free slots < write size; fifo_empty = used slots < read size. Upsize: a partially packed wide word keeps fifo_empty high.
- Write with fifo_full, or read with fifo_empty: ignored, pointers unchanged, corresponding err pulse next cycle.
- Simultaneous rd and wr: each qualified against flags at that edge; no write-through when full, no read-through when empty; level changes by net amount.
- Packing order per PACK_MSB_FIRST, applied identically to upsize assembly and downsize slicing. R = 1 degenerates to a plain FIFO.
- fifo_flush has priority over rd/wr in the same cycle; no err pulses during flush.
- Reset: fifo_full 0, fifo_empty 1, fifo_almost_full 0, fifo_almost_empty 1, fifo_level 0, err pulses 0, fifo_dout 0. Memory array not reset.

## Timing
- All flags and fifo_level registered or derived from registered pointers; they reflect a write/read one cycle after its accepting edge.
- OUTPUT_MODE 0: fifo_dout shows head word combinationally whenever fifo_empty is 0; forced to 0 while empty. Read at edge N pops; next word visible after edge N.
- OUTPUT_MODE 1: read accepted at edge N loads fifo_dout at edge N; held until next accepted read; flush clears it to 0.
- Write-to-empty-deassert latency: 1 cycle after the write completing a full read unit.
- Reset mid-operation: asynchronous return to reset values; no data survives.

## Structure
- Package sync_fifo_pkg: ratio/narrow-width helper functions, pointer width localparams, OUTPUT_MODE enumeration; elaboration-time checks (power-of-two widths, AF_LEVEL ≤ capacity).
- Sub-module sync_fifo_asym_mem: narrow-slot register array with R-slot-wide write and read ports (slot-aligned, wrap-aware); top holds pointers, flags, output register.

## Test plan
- 64→256, depth 8, mode 0: write 0x0,0x1,0x2,0x3 → fifo_empty falls one cycle after 4th write, fifo_dout = {3,2,1,0} (64-bit each), level 4.
- 256→64, mode 1: write one word {D,C,B,A}, four reads → fifo_dout A,B,C,D on successive reads, empty after 4th, level 0.
- 64→256 fill: 32 writes → fifo_full 1, level 32; 33rd write → fifo_wr_err pulse, level stays 32; rd+wr same cycle at full → level 28, write dropped.
- Read on empty → fifo_rd_err one cycle, dout stays 0; almost_empty 1 at level ≤ 4, almost_full 1 at level 31.
- Flush after 3 of 4 narrow writes → level 0, empty 1, next 4 writes form a fresh wide word.
- Assert rst_n low mid-burst (level 17) → all outputs to reset values immediately; after release, 64→64 (R=1) writes 1,2 read back 1,2.
